slave_port_arb_4m: RTL and testbench

Round-robin arbiter and transaction sequencer sharing one slave port of the 4-master request/acknowledge interconnect between four masters. It captures the winning master's command onto the slave port and holds it until the slave acknowledges. It then routes acknowledge and read data back to the owner. A programmable watchdog aborts transactions the slave never acknowledges. One instance sits in front of each slave port of the 4W4R fabric.

---
 rtl/slave_port_arb_4m.sv | 185 ++++++++++++++++++
 tb/tb_slave_port_arb_4m.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/slave_port_arb_4m.sv
// -----------------------------------------------------------------------------
// slave_port_arb_4m
// Round-robin arbiter and transaction sequencer in front of one slave port of
// the 4-master request/acknowledge interconnect.
//
// The winning master's command is captured into the slave-side registers and
// held stable until the slave acknowledges. A programmable watchdog aborts the
// transaction if the slave never answers. Acknowledge and read data are routed
// back to the owning master in the same cycle as the slave ack.
//
// Ports
//   iClk, iRst                clock, synchronous active-high reset
//   iMstReq/Cmd/Addr/Sel/WData packed per-master request and command fields
//   oMstAck, oMstErr          per-master acknowledge / abort flag
//   oMstRData                 read data shared by all masters (0 when no ack)
//   oSlv*                     registered slave command
//   iSlvAck, iSlvRData        slave acknowledge and read data
//   iToCfg                    watchdog limit in cycles, 0 disables
//   oGrant                    one-hot current owner, 0 when idle
//   oTimeout                  one-cycle pulse on watchdog abort
// -----------------------------------------------------------------------------
module slave_port_arb_4m #(
    parameter int CMD_W = 1,
    parameter int AW    = 10,
    parameter int DW    = 32,
    parameter int SW    = 4,
    parameter int TO_W  = 8
) (
    input  logic                iClk,
    input  logic                iRst,
    input  logic [3:0]          iMstReq,
    input  logic [4*CMD_W-1:0]  iMstCmd,
    input  logic [4*AW-1:0]     iMstAddr,
    input  logic [4*SW-1:0]     iMstSel,
    input  logic [4*DW-1:0]     iMstWData,
    output logic [3:0]          oMstAck,
    output logic [3:0]          oMstErr,
    output logic [DW-1:0]       oMstRData,
    output logic                oSlvReq,
    output logic [CMD_W-1:0]    oSlvCmd,
    output logic [AW-1:0]       oSlvAddr,
    output logic [SW-1:0]       oSlvSel,
    output logic [DW-1:0]       oSlvWData,
    input  logic                iSlvAck,
    input  logic [DW-1:0]       iSlvRData,
    input  logic [TO_W-1:0]     iToCfg,
    output logic [3:0]          oGrant,
    output logic                oTimeout
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic [TO_W-1:0] CNT_ONE = {{(TO_W-1){1'b0}}, 1'b1};
    localparam logic [TO_W-1:0] CNT_MAX = {TO_W{1'b1}};

    state_t             state_q, state_d;
    logic [1:0]         ptr_q, ptr_d;
    logic [3:0]         grant_q, grant_d;
    logic               slv_req_q, slv_req_d;
    logic [CMD_W-1:0]   slv_cmd_q, slv_cmd_d;
    logic [AW-1:0]      slv_addr_q, slv_addr_d;
    logic [SW-1:0]      slv_sel_q, slv_sel_d;
    logic [DW-1:0]      slv_wdata_q, slv_wdata_d;
    logic [TO_W-1:0]    cnt_q, cnt_d;

    logic               win_found_s;
    logic [1:0]         win_idx_s;
    logic [1:0]         cand_s;
    logic               ack_fire_s;
    logic               to_fire_s;

    // Round-robin search: first requester starting at ptr, wrapping mod 4.
    always_comb begin
        win_found_s = 1'b0;
        win_idx_s   = 2'd0;
        cand_s      = 2'd0;
        for (int i = 0; i < 4; i++) begin
            cand_s = ptr_q + i[1:0];
            if (!win_found_s && iMstReq[cand_s]) begin
                win_found_s = 1'b1;
                win_idx_s   = cand_s;
            end else begin
                win_found_s = win_found_s;
            end
        end
    end

    // Completion events; slave ack wins over a coinciding watchdog expiry, and
    // a reset cycle never completes the owner's transaction.
    always_comb begin
        ack_fire_s = (state_q == BUSY) && iSlvAck && !iRst;
        to_fire_s  = (state_q == BUSY) && !iSlvAck && !iRst &&
                     (iToCfg != {TO_W{1'b0}}) && (cnt_q == (iToCfg - CNT_ONE));
    end

    // Next-state logic for the IDLE/BUSY sequencer and its datapath registers.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        grant_d     = grant_q;
        slv_req_d   = slv_req_q;
        slv_cmd_d   = slv_cmd_q;
        slv_addr_d  = slv_addr_q;
        slv_sel_d   = slv_sel_q;
        slv_wdata_d = slv_wdata_q;
        cnt_d       = cnt_q;
        case (state_q)
            IDLE: begin
                if (win_found_s) begin
                    state_d     = BUSY;
                    ptr_d       = win_idx_s + 2'd1;
                    grant_d     = 4'b0001 << win_idx_s;
                    slv_req_d   = 1'b1;
                    slv_cmd_d   = iMstCmd[win_idx_s*CMD_W +: CMD_W];
                    slv_addr_d  = iMstAddr[win_idx_s*AW +: AW];
                    slv_sel_d   = iMstSel[win_idx_s*SW +: SW];
                    slv_wdata_d = iMstWData[win_idx_s*DW +: DW];
                    cnt_d       = {TO_W{1'b0}};
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                if (ack_fire_s || to_fire_s) begin
                    state_d   = IDLE;
                    grant_d   = 4'b0000;
                    slv_req_d = 1'b0;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_ONE;
                end else begin
                    cnt_d = cnt_q;
                end
            end
            default: begin
                state_d   = IDLE;
                grant_d   = 4'b0000;
                slv_req_d = 1'b0;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_q     <= IDLE;
            ptr_q       <= 2'd0;
            grant_q     <= 4'b0000;
            slv_req_q   <= 1'b0;
            slv_cmd_q   <= {CMD_W{1'b0}};
            slv_addr_q  <= {AW{1'b0}};
            slv_sel_q   <= {SW{1'b0}};
            slv_wdata_q <= {DW{1'b0}};
            cnt_q       <= {TO_W{1'b0}};
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            grant_q     <= grant_d;
            slv_req_q   <= slv_req_d;
            slv_cmd_q   <= slv_cmd_d;
            slv_addr_q  <= slv_addr_d;
            slv_sel_q   <= slv_sel_d;
            slv_wdata_q <= slv_wdata_d;
            cnt_q       <= cnt_d;
        end
    end

    // Zero-latency return path to the owner; grant_q is one-hot while BUSY.
    always_comb begin
        oMstAck   = (ack_fire_s || to_fire_s) ? grant_q : 4'b0000;
        oMstErr   = to_fire_s ? grant_q : 4'b0000;
        oMstRData = ack_fire_s ? iSlvRData : {DW{1'b0}};
        oTimeout  = to_fire_s;
    end

    assign oSlvReq   = slv_req_q;
    assign oSlvCmd   = slv_cmd_q;
    assign oSlvAddr  = slv_addr_q;
    assign oSlvSel   = slv_sel_q;
    assign oSlvWData = slv_wdata_q;
    assign oGrant    = grant_q;

endmodule

// File: tb/tb_slave_port_arb_4m.sv
module tb_slave_port_arb_4m;

    localparam int CMD_W = 1;
    localparam int AW    = 10;
    localparam int DW    = 32;
    localparam int SW    = 4;
    localparam int TO_W  = 8;

    logic                iClk = 1'b0;
    logic                iRst;
    logic [3:0]          iMstReq;
    logic [4*CMD_W-1:0]  iMstCmd;
    logic [4*AW-1:0]     iMstAddr;
    logic [4*SW-1:0]     iMstSel;
    logic [4*DW-1:0]     iMstWData;
    logic [3:0]          oMstAck;
    logic [3:0]          oMstErr;
    logic [DW-1:0]       oMstRData;
    logic                oSlvReq;
    logic [CMD_W-1:0]    oSlvCmd;
    logic [AW-1:0]       oSlvAddr;
    logic [SW-1:0]       oSlvSel;
    logic [DW-1:0]       oSlvWData;
    logic                iSlvAck;
    logic [DW-1:0]       iSlvRData;
    logic [TO_W-1:0]     iToCfg;
    logic [3:0]          oGrant;
    logic                oTimeout;

    slave_port_arb_4m dut (
        .iClk(iClk), .iRst(iRst),
        .iMstReq(iMstReq), .iMstCmd(iMstCmd), .iMstAddr(iMstAddr),
        .iMstSel(iMstSel), .iMstWData(iMstWData),
        .oMstAck(oMstAck), .oMstErr(oMstErr), .oMstRData(oMstRData),
        .oSlvReq(oSlvReq), .oSlvCmd(oSlvCmd), .oSlvAddr(oSlvAddr),
        .oSlvSel(oSlvSel), .oSlvWData(oSlvWData),
        .iSlvAck(iSlvAck), .iSlvRData(iSlvRData), .iToCfg(iToCfg),
        .oGrant(oGrant), .oTimeout(oTimeout)
    );

    always #5 iClk = ~iClk;

    typedef struct {
        int          m;
        logic        cmd;
        logic [9:0]  addr;
        logic [3:0]  sel;
        logic [31:0] wdata;
        int          ack_dly;   // BUSY cycle of slave ack, 0 = never
        logic [31:0] rdata;
        logic [7:0]  tocfg;
        bit          drop;      // owner drops request mid-transaction
    } vec_t;

    typedef struct {
        int          m;
        bit          err;
        logic [31:0] rdata;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge iClk);
        #1;
    endtask

    // Settle, then compare the return path against the scoreboard.
    task automatic sample();
        exp_t       e;
        logic [3:0] oh;
        #2;
        if (oMstAck != 4'b0000) begin
            if (sb_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL ack_unexpected: got ack %b expected none at %0t", oMstAck, $time);
            end else begin
                e  = sb_q.pop_front();
                oh = 4'b0001 << e.m;
                chk("ack_owner", 64'(oMstAck), 64'(oh));
                chk("ack_err", 64'(oMstErr), e.err ? 64'(oh) : 64'd0);
                chk("ack_rdata", 64'(oMstRData), 64'(e.rdata));
                chk("ack_timeout", 64'(oTimeout), 64'(e.err));
            end
        end else begin
            chk("quiet_err", 64'(oMstErr), 64'd0);
            chk("quiet_rdata", 64'(oMstRData), 64'd0);
            chk("quiet_timeout", 64'(oTimeout), 64'd0);
        end
    endtask

    task automatic set_fields(input int m, input logic cmd, input logic [9:0] addr,
                              input logic [3:0] sel, input logic [31:0] wdata);
        iMstCmd[m*CMD_W +: CMD_W] = cmd;
        iMstAddr[m*AW +: AW]      = addr;
        iMstSel[m*SW +: SW]       = sel;
        iMstWData[m*DW +: DW]     = wdata;
    endtask

    task automatic chk_slv_idle(input string tag);
        chk({tag, "_grant"}, 64'(oGrant), 64'd0);
        chk({tag, "_slvreq"}, 64'(oSlvReq), 64'd0);
    endtask

    task automatic reset_dut();
        cyc();
        iRst = 1'b1; iMstReq = 4'b0; iSlvAck = 1'b0; iToCfg = 8'd0;
        sample();
        cyc();
        sample();
        cyc();
        iRst = 1'b0;
        sample();
    endtask

    task automatic run_txn(input vec_t v);
        bit         is_to;
        int         end_k;
        logic [3:0] oh;
        is_to = !(v.ack_dly > 0 && (v.tocfg == 8'd0 || v.ack_dly <= int'(v.tocfg)));
        end_k = is_to ? int'(v.tocfg) : v.ack_dly;
        oh    = 4'b0001 << v.m;
        cyc();
        iToCfg = v.tocfg; iSlvRData = v.rdata; iSlvAck = 1'b0;
        iMstReq = 4'b0; iMstReq[v.m] = 1'b1;
        set_fields(v.m, v.cmd, v.addr, v.sel, v.wdata);
        sample();
        chk_slv_idle("txn_pre");
        for (int k = 1; k <= end_k; k++) begin
            cyc();
            if (k == 2) begin
                set_fields(v.m, ~v.cmd, ~v.addr, ~v.sel, ~v.wdata);
                if (v.drop) iMstReq = 4'b0;
            end
            iSlvAck = (k == end_k) && !is_to;
            if (k == end_k) sb_q.push_back('{v.m, is_to, is_to ? 32'd0 : v.rdata});
            sample();
            if (k == 1 || k == end_k) begin
                chk("txn_grant", 64'(oGrant), 64'(oh));
                chk("txn_slvreq", 64'(oSlvReq), 64'd1);
                chk("txn_cmd", 64'(oSlvCmd), 64'(v.cmd));
                chk("txn_addr", 64'(oSlvAddr), 64'(v.addr));
                chk("txn_sel", 64'(oSlvSel), 64'(v.sel));
                chk("txn_wdata", 64'(oSlvWData), 64'(v.wdata));
            end
        end
        cyc();
        iSlvAck = 1'b0; iMstReq = 4'b0;
        sample();
        chk("txn_ack_seen", 64'(sb_q.size()), 64'd0);
        sb_q.delete();
        chk_slv_idle("txn_post");
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t tbl[7];
        tbl[0] = '{2, 1'b1, 10'h005, 4'hF, 32'hA5A5_0001,   3, 32'h0000_0042, 8'd0, 1'b0};
        tbl[1] = '{1, 1'b0, 10'h3A0, 4'hF, 32'h0000_0000,   1, 32'hDEAD_BEEF, 8'd0, 1'b0};
        tbl[2] = '{0, 1'b1, 10'h011, 4'h3, 32'h1234_5678,   0, 32'h5555_AAAA, 8'd4, 1'b0};
        tbl[3] = '{3, 1'b0, 10'h3FF, 4'h8, 32'h0000_0000,   2, 32'h0BAD_F00D, 8'd2, 1'b1};
        tbl[4] = '{1, 1'b1, 10'h200, 4'h1, 32'hFFFF_FFFF,   0, 32'h7777_0000, 8'd1, 1'b0};
        tbl[5] = '{3, 1'b1, 10'h0F0, 4'hC, 32'h0F0F_0F0F,   4, 32'h1111_2222, 8'd3, 1'b1};
        tbl[6] = '{0, 1'b0, 10'h155, 4'hF, 32'h0000_0000, 301, 32'hCAFE_F00D, 8'd0, 1'b0};

        iRst = 1'b1; iMstReq = 4'b0; iMstCmd = '0; iMstAddr = '0; iMstSel = '0;
        iMstWData = '0; iSlvAck = 1'b0; iSlvRData = 32'h0; iToCfg = 8'd0;

        // Reset state.
        reset_dut();
        chk_slv_idle("rst");
        chk("rst_ack", 64'(oMstAck), 64'd0);
        chk("rst_addr", 64'(oSlvAddr), 64'd0);
        chk("rst_wdata", 64'(oSlvWData), 64'd0);
        chk("rst_sel", 64'(oSlvSel), 64'd0);
        chk("rst_cmd", 64'(oSlvCmd), 64'd0);

        // All four masters request continuously: strict rotation from master 0.
        for (int m = 0; m < 4; m++)
            set_fields(m, m[0], 10'h100 + 10'(m), 4'b0001 << m, 32'hC0DE_0000 + 32'(m));
        for (int t = 0; t < 8; t++) begin
            cyc();
            iSlvAck = 1'b0; iMstReq = 4'hF;
            sample();
            chk_slv_idle("rr_gap");
            cyc();
            iSlvAck = 1'b1; iSlvRData = 32'h1000 + 32'(t);
            sb_q.push_back('{t % 4, 1'b0, 32'h1000 + 32'(t)});
            sample();
            chk("rr_grant", 64'(oGrant), 64'(4'b0001 << (t % 4)));
            chk("rr_addr", 64'(oSlvAddr), 64'(10'h100 + 10'(t % 4)));
        end
        cyc();
        iSlvAck = 1'b0; iMstReq = 4'b0;
        sample();
        chk("rr_ack_seen", 64'(sb_q.size()), 64'd0);
        sb_q.delete();

        // Slave ack while idle must not reach any master.
        cyc();
        iSlvAck = 1'b1; iSlvRData = 32'h9999_9999;
        sample();
        chk("idle_ack_ignored", 64'(oMstAck), 64'd0);
        cyc();
        iSlvAck = 1'b0;
        sample();

        // Table-driven single-master transactions.
        for (int i = 0; i < 7; i++) run_txn(tbl[i]);

        // Reset in the middle of a transaction, then masters 0 and 3 together.
        cyc();
        iToCfg = 8'd0; iSlvAck = 1'b0; iSlvRData = 32'h4444_4444;
        iMstReq = 4'b0100;
        set_fields(2, 1'b1, 10'h2AA, 4'hF, 32'h2222_2222);
        sample();
        cyc(); sample();
        chk("mid_grant", 64'(oGrant), 64'b0100);
        cyc(); sample();
        cyc();
        iRst = 1'b1;
        sample();
        cyc();
        iRst = 1'b0; iMstReq = 4'b1001;
        set_fields(0, 1'b0, 10'h0A0, 4'h1, 32'h0000_00A0);
        set_fields(3, 1'b1, 10'h0A3, 4'h8, 32'h0000_00A3);
        sample();
        chk_slv_idle("mid_rst");
        chk("mid_rst_addr", 64'(oSlvAddr), 64'd0);
        chk("mid_rst_wdata", 64'(oSlvWData), 64'd0);
        chk("mid_rst_cmd", 64'(oSlvCmd), 64'd0);
        cyc();
        iSlvAck = 1'b1; iSlvRData = 32'hAAAA_0000;
        sb_q.push_back('{0, 1'b0, 32'hAAAA_0000});
        sample();
        chk("mid_first_grant", 64'(oGrant), 64'b0001);
        chk("mid_first_addr", 64'(oSlvAddr), 64'h0A0);
        cyc();
        iSlvAck = 1'b0; iMstReq = 4'b1000;
        sample();
        chk_slv_idle("mid_gap");
        cyc();
        iSlvAck = 1'b1; iSlvRData = 32'hAAAA_0003;
        sb_q.push_back('{3, 1'b0, 32'hAAAA_0003});
        sample();
        chk("mid_second_grant", 64'(oGrant), 64'b1000);
        chk("mid_second_addr", 64'(oSlvAddr), 64'h0A3);
        cyc();
        iSlvAck = 1'b0; iMstReq = 4'b0;
        sample();
        chk("mid_ack_seen", 64'(sb_q.size()), 64'd0);
        sb_q.delete();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
